// File: rtl/fpu_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fpu_scheduler_pkg
// Shared definitions for the FPU scheduler slice: controller state encoding,
// FPU operation codes, the round-to-nearest rounding mode, the quiet-NaN
// pattern returned on a timed-out operation, and a helper that sizes index
// vectors for N requesters.
// -----------------------------------------------------------------------------
package fpu_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [2:0]  FPU_ADD       = 3'b000;
   localparam logic [2:0]  FPU_SUB       = 3'b001;
   localparam logic [2:0]  FPU_MUL       = 3'b010;
   localparam logic [2:0]  FPU_DIV       = 3'b011;

   localparam logic [1:0]  RMODE_NEAREST = 2'b00;

   localparam logic [63:0] QNAN          = 64'h7FF8_0000_0000_0000;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpu_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search for a winner starts at
// (pointer + 1) mod N, so the requester that was served last has the lowest
// priority on the next round.
//   req     : request vector, one bit per requester
//   pointer : index of the requester granted most recently
//   grant   : one-hot winner (all zero when nothing is requested)
//   valid   : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
   import fpu_scheduler_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic          found;
   logic [PW-1:0] idx;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(pointer) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/fpu_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_scheduler
// Shares one external FPU between N_REQ requesters. One operation is in
// flight at a time: the round-robin winner's operands are registered onto the
// fpu_* outputs, a one-cycle fpu_enable starts the FPU, the controller waits
// for fpu_ready to fall (ignoring a ready left high by the previous operation)
// and then rise, and reports completion with a one-hot done pulse. An FPU that
// never answers is cut off after TIMEOUT_CYC cycles with a quiet-NaN result.
//   clk_operation, rst         : clock, synchronous active-high reset
//   req / req_opa / req_opb /
//   req_fpu_op / req_rmode     : per-requester request level and operands
//   gnt                        : one-hot owner of the FPU (ISSUE .. WAIT_HI)
//   done, err_timeout          : one-cycle completion / timeout pulses
//   result                     : last result, held until the next done
//   fpu_enable, fpu_opa, fpu_opb,
//   fpu_op, fpu_rmode          : start pulse and registered operands to FPU
//   fpu_out, fpu_ready         : FPU result and ready
// -----------------------------------------------------------------------------
module fpu_scheduler
   import fpu_scheduler_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 400
) (
   input  logic                 clk_operation,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [64*N_REQ-1:0]  req_opa,
   input  logic [64*N_REQ-1:0]  req_opb,
   input  logic [3*N_REQ-1:0]   req_fpu_op,
   input  logic [2*N_REQ-1:0]   req_rmode,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [63:0]          result,
   output logic                 err_timeout,
   output logic                 fpu_enable,
   output logic [63:0]          fpu_opa,
   output logic [63:0]          fpu_opb,
   output logic [2:0]           fpu_op,
   output logic [1:0]           fpu_rmode,
   input  logic [63:0]          fpu_out,
   input  logic                 fpu_ready
);

   localparam int PW = idx_width(N_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   gnt_q;
   logic [PW-1:0]      owner_q;
   logic [PW-1:0]      rr_ptr;
   logic [TW-1:0]      tmo_cnt;
   logic               timed_out_q;

   logic [N_REQ-1:0]   arb_gnt;
   logic               arb_valid;
   logic [PW-1:0]      arb_idx;
   logic [63:0]        sel_opa, sel_opb;
   logic [2:0]         sel_op;
   logic [1:0]         sel_rmode;
   logic               timeout_hit;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
      .req     (req),
      .pointer (rr_ptr),
      .grant   (arb_gnt),
      .valid   (arb_valid)
   );

   // Steer the winner's operand slices and index out of the one-hot grant.
   always_comb begin
      arb_idx   = '0;
      sel_opa   = '0;
      sel_opb   = '0;
      sel_op    = '0;
      sel_rmode = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            arb_idx   = PW'(i);
            sel_opa   = req_opa[i*64 +: 64];
            sel_opb   = req_opb[i*64 +: 64];
            sel_op    = req_fpu_op[i*3 +: 3];
            sel_rmode = req_rmode[i*2 +: 2];
         end
      end
   end

   // tmo_cnt is cleared in ISSUE and counts wait cycles, so it reads j-1 in the
   // j-th cycle after ISSUE. Hitting TIMEOUT_CYC-2 here makes DONE land exactly
   // TIMEOUT_CYC cycles after ISSUE.
   assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 2));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_operation) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT_LO;
         WAIT_LO: begin
            if (timeout_hit)     state_nxt = DONE;
            else if (!fpu_ready) state_nxt = WAIT_HI;
         end
         // A real answer in the same cycle as the timeout wins.
         WAIT_HI: if (fpu_ready || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fpu_enable  = (state == ISSUE);
      gnt         = (state == DONE) ? '0 : gnt_q;
      done        = (state == DONE) ? gnt_q : '0;
      err_timeout = (state == DONE) && timed_out_q;
   end

   // NOTE: the wide operand and result registers are reset too, because their
   // reset value is visible on the ports.
   always_ff @(posedge clk_operation) begin
      if (rst) begin
         gnt_q       <= '0;
         owner_q     <= '0;
         rr_ptr      <= PW'(N_REQ - 1);
         tmo_cnt     <= '0;
         timed_out_q <= 1'b0;
         result      <= '0;
         fpu_opa     <= '0;
         fpu_opb     <= '0;
         fpu_op      <= '0;
         fpu_rmode   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  gnt_q     <= arb_gnt;
                  owner_q   <= arb_idx;
                  fpu_opa   <= sel_opa;
                  fpu_opb   <= sel_opb;
                  fpu_op    <= sel_op;
                  fpu_rmode <= sel_rmode;
               end
            end
            ISSUE: begin
               tmo_cnt     <= '0;
               timed_out_q <= 1'b0;
            end
            WAIT_LO: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (timeout_hit) begin
                  result      <= QNAN;
                  timed_out_q <= 1'b1;
               end
            end
            WAIT_HI: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (fpu_ready) begin
                  result <= fpu_out;
               end else if (timeout_hit) begin
                  result      <= QNAN;
                  timed_out_q <= 1'b1;
               end
            end
            DONE: begin
               gnt_q  <= '0;
               rr_ptr <= owner_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fpu_scheduler
// Self-checking bench for fpu_scheduler. A behavioural FPU stand-in is driven
// from the directed stimulus. A transaction-level model (round-robin pick over
// pending requests, per-operation ready history, timeout deadline) predicts
// gnt, done, fpu_enable, err_timeout, result and the fpu_* operands, and one
// compare process checks them on every falling edge. Directed scenarios add
// literal expectations for results, grant order and timeout latency.
// -----------------------------------------------------------------------------
module tb_fpu_scheduler;
   import fpu_scheduler_pkg::*;

   localparam int N = 4;
   localparam int T = 400;

   logic              clk_operation = 1'b0;
   logic              rst           = 1'b1;
   logic [N-1:0]      req           = '0;
   logic [64*N-1:0]   req_opa       = '0;
   logic [64*N-1:0]   req_opb       = '0;
   logic [3*N-1:0]    req_fpu_op    = '0;
   logic [2*N-1:0]    req_rmode     = '0;
   logic [N-1:0]      gnt, done;
   logic [63:0]       result;
   logic              err_timeout, fpu_enable;
   logic [63:0]       fpu_opa, fpu_opb;
   logic [2:0]        fpu_op;
   logic [1:0]        fpu_rmode;
   logic [63:0]       fpu_out       = '0;
   logic              fpu_ready     = 1'b0;

   fpu_scheduler #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
      .clk_operation (clk_operation),
      .rst           (rst),
      .req           (req),
      .req_opa       (req_opa),
      .req_opb       (req_opb),
      .req_fpu_op    (req_fpu_op),
      .req_rmode     (req_rmode),
      .gnt           (gnt),
      .done          (done),
      .result        (result),
      .err_timeout   (err_timeout),
      .fpu_enable    (fpu_enable),
      .fpu_opa       (fpu_opa),
      .fpu_opb       (fpu_opb),
      .fpu_op        (fpu_op),
      .fpu_rmode     (fpu_rmode),
      .fpu_out       (fpu_out),
      .fpu_ready     (fpu_ready)
   );

   always #5 clk_operation = ~clk_operation;

   int cyc = 0;
   always @(posedge clk_operation) cyc++;

   int n_vec = 0;
   int n_bad = 0;
   int n_enable = 0;
   int n_done = 0;
   int grant_log[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s @cyc %0d: got no response, want one within the cycle budget", name, cyc);
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [63:0] fpu_calc(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op);
      real ra, rb, r;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      case (op)
         FPU_ADD: r = ra + rb;
         FPU_SUB: r = ra - rb;
         FPU_MUL: r = ra * rb;
         default: r = ra / rb;
      endcase
      return $realtobits(r);
   endfunction

   function automatic int log_at(input int i);
      if (i < grant_log.size()) return grant_log[i];
      return -1;
   endfunction

   // ---------------------------------------------------------------- model
   bit             p_rst      = 1'b1;
   logic [N-1:0]   p_req      = '0;
   logic [64*N-1:0] p_opa     = '0;
   logic [64*N-1:0] p_opb     = '0;
   logic [3*N-1:0] p_op       = '0;
   logic [2*N-1:0] p_rmode    = '0;
   logic [N-1:0]   gnt_prev   = '0;

   bit             m_own      = 1'b0;
   int             m_owner    = 0;
   int             m_issue    = 0;
   int             m_last     = N - 1;
   int             m_done_cyc = -10;
   bit             m_low      = 1'b0;
   bit             m_rise     = 1'b0;
   int             m_rise_cyc = 0;
   logic [63:0]    m_rise_val = '0;
   logic [63:0]    m_result   = '0;
   logic [63:0]    m_opa      = '0;
   logic [63:0]    m_opb      = '0;
   logic [2:0]     m_op       = '0;
   logic [1:0]     m_rmode    = '0;

   always @(negedge clk_operation) begin : cmp
      logic [N-1:0] e_gnt, e_done, own_oh;
      logic         e_en, e_err;
      bit           hit_n, hit_t;
      int           w;
      e_gnt  = '0;
      e_done = '0;
      e_en   = 1'b0;
      e_err  = 1'b0;
      if (p_rst) begin
         m_own      = 1'b0;
         m_last     = N - 1;
         m_result   = '0;
         m_opa      = '0;
         m_opb      = '0;
         m_op       = '0;
         m_rmode    = '0;
         m_done_cyc = -10;
      end else begin
         // A grant follows any cycle in which the FPU was free and something was pending.
         if (!m_own && m_done_cyc != cyc - 1 && p_req != '0) begin
            w       = rr_pick(p_req, m_last);
            m_own   = 1'b1;
            m_owner = w;
            m_issue = cyc;
            m_low   = 1'b0;
            m_rise  = 1'b0;
            m_opa   = p_opa[w*64 +: 64];
            m_opb   = p_opb[w*64 +: 64];
            m_op    = p_op[w*3 +: 3];
            m_rmode = p_rmode[w*2 +: 2];
         end
         if (m_own) begin
            own_oh = N'(1) << m_owner;
            if (cyc == m_issue) begin
               e_gnt = own_oh;
               e_en  = 1'b1;
            end else begin
               hit_n = m_rise && (cyc == m_rise_cyc + 1);
               hit_t = (cyc == m_issue + T);
               if (hit_n || hit_t) begin
                  e_done     = own_oh;
                  e_err      = !hit_n;
                  m_result   = hit_n ? m_rise_val : QNAN;
                  m_own      = 1'b0;
                  m_last     = m_owner;
                  m_done_cyc = cyc;
               end else begin
                  e_gnt = own_oh;
                  if (!m_low && fpu_ready === 1'b0) begin
                     m_low = 1'b1;
                  end else if (m_low && !m_rise && fpu_ready === 1'b1) begin
                     m_rise     = 1'b1;
                     m_rise_cyc = cyc;
                     m_rise_val = fpu_out;
                  end
               end
            end
         end
      end

      check("gnt",         64'(gnt),         64'(e_gnt));
      check("done",        64'(done),        64'(e_done));
      check("fpu_enable",  64'(fpu_enable),  64'(e_en));
      check("err_timeout", 64'(err_timeout), 64'(e_err));
      check("result",      result,           m_result);
      check("fpu_opa",     fpu_opa,          m_opa);
      check("fpu_opb",     fpu_opb,          m_opb);
      check("fpu_op",      64'(fpu_op),      64'(m_op));
      check("fpu_rmode",   64'(fpu_rmode),   64'(m_rmode));

      if (fpu_enable === 1'b1) n_enable++;
      if (done !== '0) n_done++;
      if (gnt_prev == '0 && gnt != '0) begin
         for (int i = 0; i < N; i++) if (gnt[i]) grant_log.push_back(i);
      end
      gnt_prev = gnt;
      p_rst    = rst;
      p_req    = req;
      p_opa    = req_opa;
      p_opb    = req_opb;
      p_op     = req_fpu_op;
      p_rmode  = req_rmode;
   end

   // ---------------------------------------------------------------- stimulus
   task automatic step();
      @(posedge clk_operation);
      #2;
   endtask

   task automatic set_req(input int i, input real a, input real b, input logic [2:0] op);
      req_opa[i*64 +: 64]  = $realtobits(a);
      req_opb[i*64 +: 64]  = $realtobits(b);
      req_fpu_op[i*3 +: 3] = op;
      req_rmode[i*2 +: 2]  = RMODE_NEAREST;
   endtask

   task automatic wait_enable(output int c);
      int n;
      n = 0;
      c = -1;
      do begin
         @(negedge clk_operation);
         n++;
      end while (fpu_enable !== 1'b1 && n < 50);
      if (fpu_enable === 1'b1) c = cyc;
      else bound_fail("wait_enable");
   endtask

   task automatic wait_done(output int c, output logic [N-1:0] dv,
                            output logic [63:0] res, output logic err);
      int n;
      n   = 0;
      c   = -1;
      dv  = '0;
      res = '0;
      err = 1'b0;
      do begin
         @(negedge clk_operation);
         n++;
      end while (done === '0 && n < T + 100);
      if (done !== '0) begin
         c   = cyc;
         dv  = done;
         res = result;
         err = err_timeout;
      end else begin
         bound_fail("wait_done");
      end
   endtask

   // Behaves as the FPU for one operation: keep ready for `stale` cycles, drop
   // it, then raise it with the computed result `k` cycles later (or never).
   task automatic run_op(input int stale, input int k, input bit never, input logic [N-1:0] drop,
                         output int ic, output int dc, output logic [N-1:0] dv,
                         output logic [63:0] res, output logic err);
      wait_enable(ic);
      step();
      req = req & ~drop;
      repeat (stale) step();
      fpu_ready = 1'b0;
      if (!never) begin
         repeat (k) step();
         fpu_out   = fpu_calc(fpu_opa, fpu_opb, fpu_op);
         fpu_ready = 1'b1;
      end
      wait_done(dc, dv, res, err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want $finish before time limit");
      $fatal(1);
   end

   initial begin
      int          ic, dc, gl, nd0, ne0;
      logic [N-1:0] dv;
      logic [63:0] res;
      logic        err;
      int          exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};

      // Reset
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk_operation);
      check("rst_gnt",    64'(gnt),        64'h0);
      check("rst_result", result,          64'h0);
      check("rst_enable", 64'(fpu_enable), 64'h0);

      // 2.0 * 3.0 on requester 0, ready rises 60 cycles after it falls
      step();
      set_req(0, 2.0, 3.0, FPU_MUL);
      req = 4'b0001;
      nd0 = n_done;
      run_op(0, 60, 1'b0, '0, ic, dc, dv, res, err);
      step();
      req = '0;
      check("mul_done_vec", 64'(dv),  64'h1);
      check("mul_result",   res,      64'h4018_0000_0000_0000);
      check("mul_err",      64'(err), 64'h0);
      repeat (3) step();
      check("mul_done_count", 64'(n_done - nd0), 64'h1);

      // Ready still high from the previous operation for 5 cycles
      set_req(0, 1.5, 2.25, FPU_ADD);
      req = 4'b0001;
      run_op(5, 3, 1'b0, '0, ic, dc, dv, res, err);
      step();
      req = '0;
      check("stale_no_early_done", 64'((dc - ic) > 6), 64'h1);
      check("stale_result",        res,                64'h400E_0000_0000_0000);

      // FPU never answers: timeout on requester 3
      set_req(3, 1.0, 4.0, FPU_DIV);
      req = 4'b1000;
      run_op(0, 0, 1'b1, '0, ic, dc, dv, res, err);
      step();
      req = '0;
      check("tmo_latency",  64'(dc - ic), 64'(T));
      check("tmo_err",      64'(err),     64'h1);
      check("tmo_result",   res,          64'h7FF8_0000_0000_0000);
      check("tmo_done_vec", 64'(dv),      64'h8);

      // Serve requester 1 so the pointer sits at 1
      set_req(1, 5.0, 1.0, FPU_SUB);
      req = 4'b0010;
      run_op(0, 4, 1'b0, '0, ic, dc, dv, res, err);
      step();
      req = '0;
      check("sub_result", res, 64'h4010_0000_0000_0000);

      // req[2] wins, drops after grant and still completes; then req[1]
      step();
      set_req(1, 1.0, 1.0, FPU_ADD);
      set_req(2, 2.0, 2.0, FPU_MUL);
      req = 4'b0110;
      gl  = grant_log.size();
      run_op(0, 2, 1'b0, 4'b0100, ic, dc, dv, res, err);
      check("drop_done_vec", 64'(dv), 64'h4);
      check("drop_result",   res,     64'h4010_0000_0000_0000);
      run_op(0, 2, 1'b0, '0, ic, dc, dv, res, err);
      step();
      req = '0;
      check("next_done_vec", 64'(dv), 64'h2);
      check("next_result",   res,     64'h4000_0000_0000_0000);
      check("order_drop_0",  64'(log_at(gl)),     64'h2);
      check("order_drop_1",  64'(log_at(gl + 1)), 64'h1);

      // Reset in WAIT_HI aborts the operation without done
      step();
      set_req(0, 2.0, 3.0, FPU_MUL);
      req = 4'b0001;
      nd0 = n_done;
      wait_enable(ic);
      step();
      fpu_ready = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      set_req(0, 1.0, 2.0, FPU_ADD);
      set_req(1, 3.0, 1.0, FPU_SUB);
      set_req(2, 1.5, 4.0, FPU_MUL);
      set_req(3, 9.0, 3.0, FPU_DIV);
      req = 4'b1111;
      step();
      rst = 1'b0;
      @(negedge clk_operation);
      check("abort_gnt",     64'(gnt),          64'h0);
      check("abort_done",    64'(done),         64'h0);
      check("abort_result",  result,            64'h0);
      check("abort_opa",     fpu_opa,           64'h0);
      check("abort_enable",  64'(fpu_enable),   64'h0);
      check("abort_no_done", 64'(n_done - nd0), 64'h0);

      // All four requesting continuously: 0,1,2,3,0
      gl  = grant_log.size();
      ne0 = n_enable;
      for (int i = 0; i < 5; i++) begin
         run_op(0, 2 + i, 1'b0, '0, ic, dc, dv, res, err);
      end
      step();
      req = '0;
      repeat (5) step();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr_order_%0d", i), 64'(log_at(gl + i)), 64'(exp_order[i]));
      end
      check("rr_enable_count", 64'(n_enable - ne0), 64'h5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
